// File: rtl/shift_seq_ctrl_pkg.sv
// Shared definitions for the shift register command sequencer: opcodes,
// register mode selects and FSM state encoding.
package shift_seq_ctrl_pkg;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_SHL  = 2'b01;
    localparam logic [1:0] OP_SHR  = 2'b10;
    localparam logic [1:0] OP_NOP  = 2'b11;

    localparam logic [1:0] SEL_LOAD = 2'b00;
    localparam logic [1:0] SEL_SHL  = 2'b01;
    localparam logic [1:0] SEL_SHR  = 2'b10;
    localparam logic [1:0] SEL_HOLD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [1:0] op_to_sel(input logic [1:0] op);
        logic [1:0] sel;
        case (op)
            OP_LOAD: sel = SEL_LOAD;
            OP_SHL:  sel = SEL_SHL;
            OP_SHR:  sel = SEL_SHR;
            default: sel = SEL_HOLD;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/shift_step_cnt.sv
// Loadable down-counter for the number of remaining RUN steps; flags zero
// and the final step (count of one).
module shift_step_cnt
    import shift_seq_ctrl_pkg::*;
#(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero,
    output logic             last
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);
    assign last = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/shift_seq_ctrl.sv
// Command sequencer for a universal shift register: expands LOAD/SHL/SHR/NOP
// into per-cycle mode selects and tracks a shadow of the register contents.
// Optional rotate fill is built in when SHIFT_ROTATE_EN is defined.
module shift_seq_ctrl
    import shift_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    // Handshake: a command transfers on a rising edge where cmd_valid and
    // cmd_ready are both high; cmd_valid outside IDLE is ignored, not queued.
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             cmd_fill,
    input  logic             cmd_rot,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] par_out,
    output logic             sinr,
    output logic             sinl,
    output logic [WIDTH-1:0] shadow,
    output logic             done,
    output logic [1:0]       state_dbg
);

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic             fill_q, fill_d;
    logic [1:0]       sel_q, sel_d;
    logic [WIDTH-1:0] par_out_q, par_out_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             sinl_q, sinl_d;
    logic             sinr_q, sinr_d;
    logic             fill_shl, fill_shr;
    logic             cnt_load, cnt_dec, cnt_zero, cnt_last;
    logic [CNT_W-1:0] cnt_load_val;
`ifdef SHIFT_ROTATE_EN
    logic             rot_q, rot_d;
`else
    logic             unused_rot;
    assign unused_rot = cmd_rot;
`endif

    shift_step_cnt #(.CNT_W(CNT_W)) u_step_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero),
        .last     (cnt_last)
    );

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        fill_d       = fill_q;
        par_out_d    = par_out_q;
        shadow_d     = shadow_q;
        cnt_load     = 1'b0;
        cnt_load_val = cmd_count;
        cnt_dec      = 1'b0;
        sel_d        = SEL_HOLD;
        sinl_d       = 1'b0;
        sinr_d       = 1'b0;
        fill_shl     = 1'b0;
        fill_shr     = 1'b0;
`ifdef SHIFT_ROTATE_EN
        rot_d        = rot_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d   = cmd_op;
                    fill_d = cmd_fill;
`ifdef SHIFT_ROTATE_EN
                    rot_d  = cmd_rot;
`endif
                    case (cmd_op)
                        OP_LOAD: begin
                            state_d      = ST_RUN;
                            cnt_load     = 1'b1;
                            cnt_load_val = CNT_W'(1);
                            par_out_d    = cmd_data;
                        end
                        OP_SHL, OP_SHR: begin
                            cnt_load = 1'b1;
                            state_d  = (cmd_count == '0) ? ST_DONE : ST_RUN;
                        end
                        default: state_d = ST_DONE;
                    endcase
                end
            end
            ST_RUN: begin
                cnt_dec = 1'b1;
                // The shadow follows exactly what the register sees this cycle.
                case (sel_q)
                    SEL_LOAD: shadow_d = par_out_q;
                    SEL_SHL:  shadow_d = {shadow_q[WIDTH-2:0], sinl_q};
                    SEL_SHR:  shadow_d = {sinr_q, shadow_q[WIDTH-1:1]};
                    default:  ;
                endcase
                if (cnt_last || cnt_zero) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Fill for the step about to run is taken from the post-edge shadow.
`ifdef SHIFT_ROTATE_EN
        fill_shl = rot_d ? shadow_d[WIDTH-1] : fill_d;
        fill_shr = rot_d ? shadow_d[0] : fill_d;
`else
        fill_shl = fill_d;
        fill_shr = fill_d;
`endif

        if (state_d == ST_RUN) begin
            sel_d = op_to_sel(op_d);
            if (op_d == OP_SHL) sinl_d = fill_shl;
            if (op_d == OP_SHR) sinr_d = fill_shr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_NOP;
            fill_q    <= 1'b0;
            par_out_q <= '0;
            shadow_q  <= '0;
            sel_q     <= SEL_HOLD;
            sinl_q    <= 1'b0;
            sinr_q    <= 1'b0;
`ifdef SHIFT_ROTATE_EN
            rot_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            fill_q    <= fill_d;
            par_out_q <= par_out_d;
            shadow_q  <= shadow_d;
            sel_q     <= sel_d;
            sinl_q    <= sinl_d;
            sinr_q    <= sinr_d;
`ifdef SHIFT_ROTATE_EN
            rot_q     <= rot_d;
`endif
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign sel       = sel_q;
    assign par_out   = par_out_q;
    assign sinl      = sinl_q;
    assign sinr      = sinr_q;
    assign shadow    = shadow_q;
    assign state_dbg = state_q;

endmodule
